// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Instruction-fetch stage of the MIPS core. It drives the fetch address to a
// synchronous instruction memory and captures the returned word. It presents
// that word to decode through an IF/ID pipeline register. It owns the program
// counter, honours decode stalls, and redirects on taken branches or jumps.
// A redirect costs exactly one bubble.
//
// Parameters
//   WORD_SIZE     width of addresses and instructions
//   RESET_VECTOR  first fetch address after reset (word-aligned)
//
// Ports
//   clk                in   rising-edge clock
//   rst                in   asynchronous, active-high reset
//   stall              in   decode cannot accept; hold IF/ID and fetch address
//   branch_taken       in   taken branch resolved this cycle
//   branch_target      in   branch destination
//   jump               in   jump decoded this cycle
//   jump_target        in   jump destination
//   addres             out  address to instruction memory (combinational)
//   instruction        in   memory word for the address sampled last edge
//   if_id_instruction  out  instruction presented to decode
//   if_id_pc_plus4     out  address of that instruction + 4
//   if_id_valid        out  IF/ID holds a real instruction
//   fetch_count        out  number of valid instructions delivered to IF/ID
//
// Flow control: if_id_valid acts as "valid" toward decode, and !stall acts as
// "ready". The IF/ID register advances only on an edge where stall is low.
// While stall is high, if_id_instruction, if_id_pc_plus4 and if_id_valid hold
// steady. No instruction is dropped or repeated across a stall. A redirect
// (branch_taken or jump) is not subject to stall: it always squashes IF/ID.
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    input  logic                 jump,
    input  logic [WORD_SIZE-1:0] jump_target,
    output logic [WORD_SIZE-1:0] addres,
    input  logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] if_id_instruction,
    output logic [WORD_SIZE-1:0] if_id_pc_plus4,
    output logic                 if_id_valid,
    output logic [31:0]          fetch_count
);

    localparam logic [WORD_SIZE-1:0] FOUR = WORD_SIZE'(4);

    logic [WORD_SIZE-1:0] pc;         // next address to issue
    logic [WORD_SIZE-1:0] req_pc;     // address whose data is on 'instruction'
    logic                 req_valid;  // 'instruction' carries a real fetch

    logic                 redirect;
    logic [WORD_SIZE-1:0] raw_target;
    logic [WORD_SIZE-1:0] target;

    // The branch is the older instruction, so it takes precedence over a
    // jump decoded in the same cycle.
    assign redirect   = branch_taken | jump;
    assign raw_target = branch_taken ? branch_target : jump_target;
    assign target     = {raw_target[WORD_SIZE-1:2], 2'b00};

    // On a stall the memory resamples req_pc, which keeps 'instruction'
    // stable for the cycle after the stall releases.
    always_comb begin
        if (redirect) begin
            addres = target;
        end else if (stall) begin
            addres = req_pc;
        end else begin
            addres = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_VECTOR;
            req_pc            <= RESET_VECTOR;
            req_valid         <= 1'b0;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
            fetch_count       <= '0;
        end else if (redirect) begin
            // The target is fetched this edge. IF/ID is squashed, because
            // its contents are on the wrong path.
            req_pc      <= target;
            req_valid   <= 1'b1;
            pc          <= target + FOUR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instruction <= instruction;
            if_id_pc_plus4    <= req_pc + FOUR;
            if_id_valid       <= req_valid;
            req_pc            <= pc;
            req_valid         <= 1'b1;
            pc                <= pc + FOUR;
            if (req_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    // ---------------- clock / reset / signals ----------------
    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] addres;
    logic [31:0] instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    // second instance: reset vector near the top of the address space
    logic        zero_b;
    logic [31:0] zero_w;
    logic [31:0] addr_w;
    logic [31:0] instr_w;
    logic [31:0] ifid_instr_w;
    logic [31:0] ifid_pc4_w;
    logic        ifid_valid_w;
    logic [31:0] count_w;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch #(.WORD_SIZE(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .addres(addres), .instruction(instruction),
        .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    instruction_fetch #(.WORD_SIZE(32), .RESET_VECTOR(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .stall(zero_b),
        .branch_taken(zero_b), .branch_target(zero_w),
        .jump(zero_b), .jump_target(zero_w),
        .addres(addr_w), .instruction(instr_w),
        .if_id_instruction(ifid_instr_w), .if_id_pc_plus4(ifid_pc4_w),
        .if_id_valid(ifid_valid_w), .fetch_count(count_w)
    );

    // Synchronous memory model: the word at byte address 4k has the value k.
    initial begin
        instruction = '0;
        instr_w     = '0;
    end
    always @(posedge clk) begin
        instruction <= addres >> 2;
        instr_w     <= addr_w >> 2;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        stall         = s;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] e_addr;   // addres before the edge, with these inputs
        logic        e_valid;  // IF/ID after the edge
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                logic [31:0] ea, logic ev, logic [31:0] ei,
                                logic [31:0] ep, logic [31:0] ec);
        vec_t v;
        v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt;
        v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep; v.e_count = ec;
        return v;
    endfunction

    // ---------------- reference model (delivery stream) ----------------
    // m_next  : address of the next instruction decode should receive
    // m_bubble: the next advancing edge delivers nothing (start-up gap)
    logic [31:0] m_next;
    logic        m_bubble;
    logic        m_valid;
    logic [31:0] m_pc4;
    logic [31:0] m_count;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_next   = 32'h0;
        m_bubble = 1'b1;
        m_valid  = 1'b0;
        m_pc4    = 32'h0;
        m_count  = 32'h0;
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        s, b, j;
        logic [31:0] bt, jt, t, ea;

        zero_b = 1'b0;
        zero_w = '0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, if_id_valid}, 32'h0);
        check("reset_instr", if_id_instruction, 32'h0);
        check("reset_pc4", if_id_pc_plus4, 32'h0);
        check("reset_count", fetch_count, 32'h0);
        check("reset_addr", addres, 32'h0);
        check("reset_addr_w", addr_w, 32'hFFFF_FFF8);

        // wrap-around of the program counter (second instance)
        rst = 1'b0;
        #1 check("wrap_addr0", addr_w, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        check("wrap_addr1", addr_w, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap_addr2", addr_w, 32'h0000_0000);
        check("wrap_valid", {31'b0, ifid_valid_w}, 32'h1);
        check("wrap_instr0", ifid_instr_w, 32'h3FFF_FFFE);
        check("wrap_pc4_0", ifid_pc4_w, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap_instr1", ifid_instr_w, 32'h3FFF_FFFF);
        check("wrap_pc4_1", ifid_pc4_w, 32'h0000_0000);

        // back to reset for the directed table
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        vecs[0]  = mk(0,0,0,0,0, 32'h00, 0, 0, 0, 0);
        vecs[1]  = mk(0,0,0,0,0, 32'h04, 1, 0, 32'h04, 1);
        vecs[2]  = mk(0,0,0,0,0, 32'h08, 1, 1, 32'h08, 2);
        vecs[3]  = mk(0,0,0,0,0, 32'h0C, 1, 2, 32'h0C, 3);
        vecs[4]  = mk(0,0,0,0,0, 32'h10, 1, 3, 32'h10, 4);
        vecs[5]  = mk(0,0,0,0,0, 32'h14, 1, 4, 32'h14, 5);
        vecs[6]  = mk(0,0,0,0,0, 32'h18, 1, 5, 32'h18, 6);
        vecs[7]  = mk(1,0,0,0,0, 32'h18, 1, 5, 32'h18, 6);
        vecs[8]  = mk(1,0,0,0,0, 32'h18, 1, 5, 32'h18, 6);
        vecs[9]  = mk(1,0,0,0,0, 32'h18, 1, 5, 32'h18, 6);
        vecs[10] = mk(0,0,0,0,0, 32'h1C, 1, 6, 32'h1C, 7);
        vecs[11] = mk(0,0,0,0,0, 32'h20, 1, 7, 32'h20, 8);
        vecs[12] = mk(0,1,32'h40,0,0, 32'h40, 0, 0, 0, 8);
        vecs[13] = mk(0,0,0,0,0, 32'h44, 1, 32'h10, 32'h44, 9);
        vecs[14] = mk(1,1,32'h80,1,32'h100, 32'h80, 0, 0, 0, 9);
        vecs[15] = mk(0,0,0,0,0, 32'h84, 1, 32'h20, 32'h84, 10);
        vecs[16] = mk(0,0,0,1,32'h103, 32'h100, 0, 0, 0, 10);
        vecs[17] = mk(1,0,0,0,0, 32'h100, 0, 0, 0, 10);
        vecs[18] = mk(0,0,0,0,0, 32'h104, 1, 32'h40, 32'h104, 11);
        vecs[19] = mk(0,0,0,1,32'h200, 32'h200, 0, 0, 0, 11);
        vecs[20] = mk(0,1,32'h300,0,0, 32'h300, 0, 0, 0, 11);
        vecs[21] = mk(0,0,0,0,0, 32'h304, 1, 32'hC0, 32'h304, 12);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt);
            #1 check($sformatf("vec%0d_addr", i), addres, vecs[i].e_addr);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_count", i), fetch_count, vecs[i].e_count);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_instr", i), if_id_instruction, vecs[i].e_instr);
                check($sformatf("vec%0d_pc4", i), if_id_pc_plus4, vecs[i].e_pc4);
            end
        end
        drive(0, 0, 0, 0, 0);

        // asynchronous reset in the middle of a cycle, no edge in between
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("async_rst_count", fetch_count, 32'h0);
        check("async_rst_instr", if_id_instruction, 32'h0);
        check("async_rst_pc4", if_id_pc_plus4, 32'h0);
        check("async_rst_addr", addres, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // randomized run against the delivery-stream model
        for (int n = 0; n < 400; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            bt = $urandom;
            jt = $urandom;
            drive(s, b, bt, j, jt);

            t  = b ? bt : jt;
            t[1:0] = 2'b00;
            if (b | j)               ea = t;
            else if (s | m_bubble)   ea = m_next;
            else                     ea = m_next + 32'd4;
            #1 check("rand_addr", addres, ea);

            if (b | j) begin
                m_valid  = 1'b0;
                m_next   = t;
                m_bubble = 1'b0;
            end else if (!s) begin
                if (m_bubble) begin
                    m_valid  = 1'b0;
                    m_bubble = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    exp_q.push_back(m_next >> 2);
                    if (exp_q.size() > 4) void'(exp_q.pop_front());
                    m_pc4   = m_next + 32'd4;
                    m_next  = m_next + 32'd4;
                    m_count = m_count + 32'd1;
                end
            end

            @(posedge clk); #1;
            check("rand_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            check("rand_count", fetch_count, m_count);
            if (m_valid) begin
                check("rand_instr", if_id_instruction, exp_q[exp_q.size()-1]);
                check("rand_pc4", if_id_pc_plus4, m_pc4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
